// File: rtl/bsg_rx.sv
// BSG modulated-link receiver: slices the sample stream into symbols, Gray-decodes
// each frame into ping-pong data registers. Optional BSG_RX_MAJORITY_EN: 2-of-3 voting.
module bsg_rx #(
  parameter int         SPS    = 8,
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic       G_CLK_RX,
  input  logic       reset,
  input  logic [7:0] IN,
  input  logic       RX_ENABLE,
  input  logic       INTMSK,
  input  logic       INT_CLR,
  output logic [7:0] RX_DATA_1,
  output logic [7:0] RX_DATA_2,
  output logic [7:0] RX_CONTROL,
  output logic       rx_valid,
  output logic       IRQ
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = $clog2(SPS + 1);
`ifdef BSG_RX_MAJORITY_EN
  // Voting delays every decision by one sample, so the first one lands at mid+1.
  localparam logic [CW-1:0] START_CNT = CW'(SPS / 2);
`else
  localparam logic [CW-1:0] START_CNT = CW'(SPS / 2 - 1);
`endif
  localparam logic [CW-1:0] SYM_CNT = CW'(SPS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data1_q, data1_d;
  logic [7:0]      data2_q, data2_d;
  logic            slot_q, slot_d;
  logic            intflag_q, intflag_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            valid_q, valid_d;
  logic            irq_q, irq_d;

  logic            cmp;
  logic            sym;
  logic            tick;
  logic            good;
  logic            bad;

  function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign cmp = (IN >= THRESH);

`ifdef BSG_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], cmp};
  assign sym    = (hist_q[1] & hist_q[0]) | (hist_q[1] & cmp) | (hist_q[0] & cmp);
`else
  assign sym = cmp;
`endif

  assign tick = (state_q == START) ? (cnt_q == START_CNT) : (cnt_q == SYM_CNT);
  assign good = (state_q == STOP) && tick && RX_ENABLE && !sym;
  assign bad  = (state_q == STOP) && tick && RX_ENABLE && sym;

  // State and datapath registers
  always_ff @(posedge G_CLK_RX or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      slot_q    <= 1'b0;
      intflag_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      valid_q   <= 1'b0;
      irq_q     <= 1'b0;
`ifdef BSG_RX_MAJORITY_EN
      hist_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      slot_q    <= slot_d;
      intflag_q <= intflag_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      irq_q     <= irq_d;
`ifdef BSG_RX_MAJORITY_EN
      hist_q    <= hist_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmp) state_d = START;
      START:   if (tick) state_d = sym ? DATA : IDLE;
      DATA:    if (tick && bitcnt_q == 3'd7) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!RX_ENABLE) state_d = IDLE;
  end

  // Datapath and flag updates
  always_comb begin
    cnt_d    = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    if (state_q == START) bitcnt_d = '0;
    if (state_q == DATA && tick) begin
      bitcnt_d = bitcnt_q + 3'd1;
      shift_d  = {shift_q[6:0], sym};
    end

    data1_d = data1_q;
    data2_d = data2_q;
    slot_d  = slot_q;
    if (good) begin
      if (slot_q) data2_d = gray_to_bin(shift_q);
      else        data1_d = gray_to_bin(shift_q);
      slot_d = ~slot_q;
    end
    valid_d = good;

    // A set in the same cycle as INT_CLR takes priority over the clear.
    intflag_d = (good || bad)          ? 1'b1 : (INT_CLR ? 1'b0 : intflag_q);
    ferr_d    = bad                    ? 1'b1 : (INT_CLR ? 1'b0 : ferr_q);
    ovr_d     = (good && intflag_q)    ? 1'b1 : (INT_CLR ? 1'b0 : ovr_q);
    irq_d     = intflag_q & INTMSK;
  end

  assign RX_DATA_1  = data1_q;
  assign RX_DATA_2  = data2_q;
  assign rx_valid   = valid_q;
  assign IRQ        = irq_q;
  assign RX_CONTROL = {1'b0, slot_q, ovr_q, ferr_q, (state_q != IDLE), intflag_q, INTMSK, RX_ENABLE};

endmodule

// File: tb/tb_bsg_rx.sv
// Self-checking bench for bsg_rx: table vectors, hand sequences for corner cases
// and random frames against a frame-level reference model.
module tb_bsg_rx;
  localparam int SPS = 8;
  localparam int NS  = 10 * SPS;
`ifdef BSG_RX_MAJORITY_EN
  localparam int LAT = SPS / 2 + 9 * SPS + 1;
`else
  localparam int LAT = SPS / 2 + 9 * SPS;
`endif
  localparam logic [7:0] HI = 8'hF0;
  localparam logic [7:0] LO = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_s;
  logic       en, msk, clr;
  logic [7:0] d1, d2, ctrl;
  logic       vld, irq;

  always #5 clk = ~clk;

  bsg_rx #(.SPS(SPS), .THRESH(8'd128)) dut (
    .G_CLK_RX(clk), .reset(rst_n), .IN(in_s), .RX_ENABLE(en), .INTMSK(msk),
    .INT_CLR(clr), .RX_DATA_1(d1), .RX_DATA_2(d2), .RX_CONTROL(ctrl),
    .rx_valid(vld), .IRQ(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_d1, m_d2;
  logic       m_slot, m_flag, m_ferr, m_ovr;

  logic       stat_hist [NS];
  logic       irq_hist  [NS];
  logic [7:0] ctrl_hist [NS];
  int         vld_cnt, vld_at;

  typedef struct {
    logic [7:0] gray;
    logic [7:0] bin;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [7:0] ctrl_exp();
    return {1'b0, m_slot, m_ovr, m_ferr, 1'b0, m_flag, msk, en};
  endfunction

  task automatic model_reset();
    m_d1 = 8'h00; m_d2 = 8'h00;
    m_slot = 1'b0; m_flag = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] g, input bit stop_hi);
    if (!stop_hi) begin
      if (m_slot) m_d2 = gray2bin(g);
      else        m_d1 = gray2bin(g);
      m_slot = ~m_slot;
      if (m_flag) m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    m_flag = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_s = LO;
    repeat (n) step();
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_flag = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_d1"}, d1, m_d1);
    chk({tag, "_d2"}, d2, m_d2);
    chk({tag, "_ctrl"}, ctrl, ctrl_exp());
  endtask

  // Sample j of the frame is seen by edge t0+j; outputs are read 1ns after it.
  task automatic run_frame(input logic [7:0] g, input bit stop_hi, input int flip_j,
                           input int drop_j, input int abort_j);
    vld_cnt = 0;
    vld_at  = -1;
    for (int j = 0; j < NS; j++) begin
      int sym;
      bit lvl;
      sym = j / SPS;
      if (sym == 0)      lvl = 1'b1;
      else if (sym == 9) lvl = stop_hi;
      else               lvl = g[8 - sym];
      if (j == flip_j) lvl = 1'b0;
      if (j == drop_j) en = 1'b0;
      in_s = lvl ? HI : LO;
      step();
      stat_hist[j] = ctrl[3];
      irq_hist[j]  = irq;
      ctrl_hist[j] = ctrl;
      if (vld) begin
        vld_cnt++;
        if (vld_at < 0) vld_at = j;
      end
      if (j == abort_j) return;
    end
    in_s = LO;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hF7, 8'hA5};
    tbl[1] = '{8'h00, 8'h00};
    tbl[2] = '{8'hFF, 8'hAA};
    tbl[3] = '{8'h01, 8'h01};
    tbl[4] = '{8'h80, 8'hFF};
    tbl[5] = '{8'h3C, 8'h28};

    rst_n = 1'b0; en = 1'b1; msk = 1'b1; clr = 1'b0; in_s = LO;
    model_reset();
    repeat (3) step();
    chk("rst_d1", d1, 8'h00);
    chk("rst_d2", d2, 8'h00);
    chk("rst_ctrl", ctrl, 8'h03);
    chk("rst_vld", vld, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // First frame: timing of rx_valid, INTFLAG and IRQ
    run_frame(tbl[0].gray, 1'b0, -1, -1, -1);
    model_frame(tbl[0].gray, 1'b0);
    chk("f1_vld_cnt", vld_cnt, 1);
    chk("f1_vld_at", vld_at, LAT);
    chk("f1_flag_before", ctrl_hist[LAT-1][2], 1'b0);
    chk("f1_flag_at", ctrl_hist[LAT][2], 1'b1);
    chk("f1_irq_at", irq_hist[LAT], 1'b0);
    chk("f1_irq_after", irq_hist[LAT+1], 1'b1);
    idle(16);
    chk("f1_data", d1, tbl[0].bin);
    check_state("f1");
    chk("f1_irq", irq, 1'b1);

    // Second frame without clear: odd slot and overrun
    run_frame(tbl[1].gray, 1'b0, -1, -1, -1);
    model_frame(tbl[1].gray, 1'b0);
    idle(16);
    chk("f2_data", d2, tbl[1].bin);
    chk("f2_ovr", ctrl[5], 1'b1);
    check_state("f2");
    clear_pulse();
    check_state("f2_clr");
    step();
    chk("f2_irq_clr", irq, 1'b0);

    // Remaining table vectors
    for (int i = 2; i < 6; i++) begin
      logic slot_before;
      slot_before = m_slot;
      run_frame(tbl[i].gray, 1'b0, -1, -1, -1);
      model_frame(tbl[i].gray, 1'b0);
      chk("tbl_vld_at", vld_at, LAT);
      idle(16);
      chk("tbl_data", slot_before ? d2 : d1, tbl[i].bin);
      check_state("tbl");
    end
    clear_pulse();

    // Two-sample pulse on an idle line is rejected as a glitch
    in_s = HI;
    step();
    chk("gl_busy", ctrl[3], 1'b1);
    step();
    in_s = LO;
    vld_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (vld) vld_cnt++;
    end
    chk("gl_vld", vld_cnt, 0);
    chk("gl_idle", ctrl[3], 1'b0);
    check_state("gl");

    // Stop symbol high: framing error, data and slot untouched
    run_frame(8'h5A, 1'b1, -1, -1, -1);
    model_frame(8'h5A, 1'b1);
    chk("fe_vld", vld_cnt, 0);
    idle(16);
    chk("fe_ferr", ctrl[4], 1'b1);
    check_state("fe");
    clear_pulse();

    // RX_ENABLE dropped mid-frame
    run_frame(8'h33, 1'b0, -1, 40, -1);
    chk("dr_busy39", stat_hist[39], 1'b1);
    chk("dr_idle40", stat_hist[40], 1'b0);
    chk("dr_vld", vld_cnt, 0);
    en = 1'b1;
    idle(16);
    check_state("dr");

    // Single corrupted sample inside data bit 0
`ifdef BSG_RX_MAJORITY_EN
    run_frame(8'hF7, 1'b0, SPS / 2 + SPS, -1, -1);
`else
    run_frame(8'hF7, 1'b0, SPS / 2 + SPS - 1, -1, -1);
`endif
    model_frame(8'hF7, 1'b0);
    chk("mj_vld_at", vld_at, LAT);
    idle(16);
    check_state("mj");

    // Random frames
    for (int n = 0; n < 24; n++) begin
      logic [7:0] g;
      bit         bad;
      g   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      msk = 1'($urandom);
      run_frame(g, bad, -1, -1, -1);
      model_frame(g, bad);
      chk("rnd_vld", vld_cnt, bad ? 0 : 1);
      idle(16);
      check_state("rnd");
      chk("rnd_irq", irq, m_flag & msk);
      if ($urandom_range(0, 2) == 0) begin
        clear_pulse();
        check_state("rnd_clr");
      end
    end
    msk = 1'b1;

    // Asynchronous reset in the middle of a frame
    run_frame(8'hC3, 1'b0, -1, -1, 30);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_d1", d1, 8'h00);
    chk("ar_d2", d2, 8'h00);
    chk("ar_ctrl", ctrl, 8'h03);
    chk("ar_vld", vld, 1'b0);
    chk("ar_irq", irq, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    check_state("ar_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
